// File: rtl/ex_pkg.sv
// Shared widths, forwarding-select encoding and immediate sign extension
// for the 8-bit core's execute stage.
package ex_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int IMM_W  = 3;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_WB,
    FWD_NONE
  } fwd_sel_t;

  function automatic logic [DATA_W-1:0] sign_extend(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Selects the source of operand A: r0 zero, EX/WB register, writeback bus,
// or the register-file value. The younger EX result wins over WB.
module forward_unit
  import ex_pkg::*;
#(
  parameter int ADDR_W = ex_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_write,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_NONE;
    if (rs1 == '0) begin
      sel = FWD_ZERO;
    end else if (ex_write && (ex_rd == rs1)) begin
      sel = FWD_EX;
    end else if (wb_write && (wb_rd == rs1)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarded operand A plus register or sign-extended immediate
// operand B, with result and flags captured in the EX/WB output register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = ex_pkg::DATA_W,
  parameter int ADDR_W = ex_pkg::ADDR_W,
  parameter int IMM_W  = ex_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sign_extend_in,
  input  logic              write_reg_in,
  input  logic [ADDR_W-1:0] rs1_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic [IMM_W-1:0]  unextended_in,
  input  logic              hold,
  input  logic              flush,
  input  logic              wb_write_in,
  input  logic [ADDR_W-1:0] wb_rd_in,
  input  logic [DATA_W-1:0] wb_data_in,
  output logic [DATA_W-1:0] result_out,
  output logic [ADDR_W-1:0] rd_out,
  output logic              write_reg_out,
  output logic              zero_out,
  output logic              carry_out,
  output logic              overflow_out
);

  fwd_sel_t          fwd_sel;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              overflow;
  logic              write_en;

  forward_unit #(.ADDR_W(ADDR_W)) u_forward_unit (
    .rs1      (rs1_in),
    .ex_rd    (rd_out),
    .ex_write (write_reg_out),
    .wb_rd    (wb_rd_in),
    .wb_write (wb_write_in),
    .sel      (fwd_sel)
  );

  always_comb begin
    op_a = data1_in;
    case (fwd_sel)
      FWD_ZERO: op_a = '0;
      FWD_EX:   op_a = result_out;
      FWD_WB:   op_a = wb_data_in;
      default:  op_a = data1_in;
    endcase
  end

  assign op_b     = sign_extend_in ? sign_extend(unextended_in) : data2_in;
  assign sum      = {1'b0, op_a} + {1'b0, op_b};
  assign result   = sum[DATA_W-1:0];
  assign overflow = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
  // r0 is hardwired zero, so a write to it is dropped here rather than in the register file.
  assign write_en = write_reg_in && (rd_in != '0);

  // flush inserts a bubble and beats hold; hold freezes every output field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_out    <= '0;
      rd_out        <= '0;
      write_reg_out <= 1'b0;
      zero_out      <= 1'b0;
      carry_out     <= 1'b0;
      overflow_out  <= 1'b0;
    end else if (flush) begin
      result_out    <= '0;
      rd_out        <= '0;
      write_reg_out <= 1'b0;
      zero_out      <= 1'b0;
      carry_out     <= 1'b0;
      overflow_out  <= 1'b0;
    end else if (!hold) begin
      result_out    <= result;
      rd_out        <= rd_in;
      write_reg_out <= write_en;
      zero_out      <= (result == '0);
      carry_out     <= sum[DATA_W];
      overflow_out  <= overflow;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: the driver pushes hand-computed
// expected outputs, a monitor pops and compares one entry per clock.
`timescale 1ns/1ps
module tb_ex_stage;

  localparam int W = 15;  // {result[7:0], rd[2:0], write, zero, carry, overflow}

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sign_extend_in = 1'b0;
  logic       write_reg_in = 1'b0;
  logic [2:0] rs1_in = '0;
  logic [2:0] rd_in = '0;
  logic [7:0] data1_in = '0;
  logic [7:0] data2_in = '0;
  logic [2:0] unextended_in = '0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic       wb_write_in = 1'b0;
  logic [2:0] wb_rd_in = '0;
  logic [7:0] wb_data_in = '0;
  logic [7:0] result_out;
  logic [2:0] rd_out;
  logic       write_reg_out;
  logic       zero_out;
  logic       carry_out;
  logic       overflow_out;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  ex_stage dut (
    .clk           (clk),
    .reset         (reset),
    .sign_extend_in(sign_extend_in),
    .write_reg_in  (write_reg_in),
    .rs1_in        (rs1_in),
    .rd_in         (rd_in),
    .data1_in      (data1_in),
    .data2_in      (data2_in),
    .unextended_in (unextended_in),
    .hold          (hold),
    .flush         (flush),
    .wb_write_in   (wb_write_in),
    .wb_rd_in      (wb_rd_in),
    .wb_data_in    (wb_data_in),
    .result_out    (result_out),
    .rd_out        (rd_out),
    .write_reg_out (write_reg_out),
    .zero_out      (zero_out),
    .carry_out     (carry_out),
    .overflow_out  (overflow_out)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [7:0] r, input logic [2:0] rd,
                                        input logic w, input logic z, input logic c,
                                        input logic v);
    return {r, rd, w, z, c, v};
  endfunction

  task automatic check(input string name, input logic [W-1:0] exp);
    logic [W-1:0] got;
    got = {result_out, rd_out, write_reg_out, zero_out, carry_out, overflow_out};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got result=%h rd=%0d wr=%b z=%b c=%b v=%b, expected result=%h rd=%0d wr=%b z=%b c=%b v=%b",
               name, got[14:7], got[6:4], got[3], got[2], got[1], got[0],
               exp[14:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // driver: apply one ID/EX + WB vector on the falling edge, queue its expectation
  task automatic vec(input string name, input logic sx, input logic wr,
                     input logic [2:0] rs1, input logic [2:0] rd,
                     input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] imm,
                     input logic hl, input logic fl,
                     input logic wbw, input logic [2:0] wbrd, input logic [7:0] wbd,
                     input logic [W-1:0] exp);
    @(negedge clk);
    sign_extend_in = sx;
    write_reg_in   = wr;
    rs1_in         = rs1;
    rd_in          = rd;
    data1_in       = d1;
    data2_in       = d2;
    unextended_in  = imm;
    hold           = hl;
    flush          = fl;
    wb_write_in    = wbw;
    wb_rd_in       = wbrd;
    wb_data_in     = wbd;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // monitor: the EX/WB register presents a new value every edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(name_q.pop_front(), exp_q.pop_front());
  end

  initial begin
    // all inputs non-zero while reset is applied
    sign_extend_in = 1'b1; write_reg_in = 1'b1; rs1_in = 3'd5; rd_in = 3'd6;
    data1_in = 8'h3C; data2_in = 8'h5A; unextended_in = 3'b011;
    wb_write_in = 1'b1; wb_rd_in = 3'd2; wb_data_in = 8'h99;
    #1 reset = 1'b1;
    #1 check("reset_async", pack(8'h00, 3'd0, 0, 0, 0, 0));
    #14 check("reset_held", pack(8'h00, 3'd0, 0, 0, 0, 0));
    #2 reset = 1'b0;

    //   name            sx wr rs1   rd    d1     d2     imm     hl fl wbw wbrd  wbd    expected
    vec("imm_add",       1, 1, 3'd1, 3'd3, 8'h10, 8'h00, 3'b101, 0, 0, 0, 3'd0, 8'h00, pack(8'h0D, 3'd3, 1, 0, 1, 0));
    vec("ovf_setup",     0, 1, 3'd1, 3'd2, 8'h7F, 8'h01, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h80, 3'd2, 1, 0, 0, 1));
    vec("ex_fwd",        1, 1, 3'd2, 3'd5, 8'h00, 8'h00, 3'b001, 0, 0, 0, 3'd0, 8'h00, pack(8'h81, 3'd5, 1, 0, 0, 0));
    vec("r4_setup",      0, 1, 3'd1, 3'd4, 8'h04, 8'h01, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h05, 3'd4, 1, 0, 0, 0));
    vec("ex_over_wb",    0, 1, 3'd4, 3'd6, 8'h33, 8'h01, 3'b000, 0, 0, 1, 3'd4, 8'h20, pack(8'h06, 3'd6, 1, 0, 0, 0));
    vec("no_write_zero", 0, 0, 3'd1, 3'd4, 8'h00, 8'h00, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h00, 3'd4, 0, 1, 0, 0));
    vec("wb_fwd",        0, 1, 3'd4, 3'd1, 8'h33, 8'h01, 3'b000, 0, 0, 1, 3'd4, 8'h20, pack(8'h21, 3'd1, 1, 0, 0, 0));
    vec("r0_src",        0, 1, 3'd0, 3'd2, 8'hAA, 8'h05, 3'b000, 0, 0, 1, 3'd0, 8'h77, pack(8'h05, 3'd2, 1, 0, 0, 0));
    vec("r0_dst_carry",  0, 1, 3'd1, 3'd0, 8'hFF, 8'h01, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h00, 3'd0, 0, 1, 1, 0));
    vec("neg_ovf",       0, 1, 3'd3, 3'd3, 8'h80, 8'h80, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h00, 3'd3, 1, 1, 1, 1));
    vec("hold_seed",     0, 1, 3'd1, 3'd7, 8'h42, 8'h00, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h42, 3'd7, 1, 0, 0, 0));
    vec("hold_1",        0, 1, 3'd2, 3'd1, 8'h11, 8'h22, 3'b000, 1, 0, 0, 3'd0, 8'h00, pack(8'h42, 3'd7, 1, 0, 0, 0));
    vec("hold_2",        1, 0, 3'd3, 3'd2, 8'hF0, 8'h0F, 3'b111, 1, 0, 1, 3'd3, 8'h55, pack(8'h42, 3'd7, 1, 0, 0, 0));
    vec("hold_3",        0, 1, 3'd7, 3'd0, 8'h80, 8'h80, 3'b000, 1, 0, 0, 3'd0, 8'h00, pack(8'h42, 3'd7, 1, 0, 0, 0));
    vec("fwd_after_hold",0, 1, 3'd7, 3'd6, 8'h00, 8'h01, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h43, 3'd6, 1, 0, 0, 0));
    vec("hold_and_flush",0, 1, 3'd1, 3'd5, 8'h12, 8'h34, 3'b000, 1, 1, 0, 3'd0, 8'h00, pack(8'h00, 3'd0, 0, 0, 0, 0));
    vec("after_flush",   0, 1, 3'd6, 3'd2, 8'h10, 8'h01, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h11, 3'd2, 1, 0, 0, 0));

    // mid-stream reset pulse between edges, inputs still non-zero
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("reset_mid", pack(8'h00, 3'd0, 0, 0, 0, 0));
    reset = 1'b0;
    #1 check("reset_release", pack(8'h00, 3'd0, 0, 0, 0, 0));

    vec("after_reset",   0, 1, 3'd2, 3'd3, 8'h01, 8'h01, 3'b000, 0, 0, 0, 3'd0, 8'h00, pack(8'h02, 3'd3, 1, 0, 0, 0));
    vec("flush_only",    0, 1, 3'd1, 3'd4, 8'h09, 8'h09, 3'b000, 0, 1, 0, 3'd0, 8'h00, pack(8'h00, 3'd0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
